// File: rtl/dmem_arb.sv
// Single-port data-memory arbiter between the CPU memory stage and a DMA/debug port.
// Define DMEM_ARB_STARVE_EN to compile in the DMA starvation counter (fairness forcing).
module dmem_arb #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic        dma_gnt,
   output logic [31:0] dma_rdata,
   output logic        dma_rvalid,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CPU  = 2'd1;
   localparam logic [1:0] ST_DMA  = 2'd2;

   if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : g_bad_starve_max
      $error("dmem_arb: STARVE_MAX must be in 1..15");
   end

   logic [1:0]  state_q, state_d;
   logic        rd_pend_q, rd_pend_d;
   logic [31:0] dma_rdata_q, dma_rdata_d;
   logic        cpu_gnt;
   logic        dma_gnt_w;
   logic        force_dma;

`ifdef DMEM_ARB_STARVE_EN
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0] starve_q, starve_d;

   // Counter reaching the limit overrides CPU priority for exactly one cycle.
   assign force_dma = dma_req && (starve_q == STARVE_LIM);

   always_comb begin
      starve_d = starve_q;
      if (dma_gnt_w || !dma_req) begin
         starve_d = 4'd0;
      end else if (cpu_gnt) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_q <= 4'd0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign force_dma = 1'b0;
`endif

   assign cpu_gnt   = cpu_req && !force_dma;
   assign dma_gnt_w = force_dma || (dma_req && !cpu_req);

   assign cpu_stall = cpu_req && !cpu_gnt;
   assign dma_gnt   = dma_gnt_w;
   assign cpu_rdata = cpu_gnt ? mem_rdata : 32'd0;

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      if (cpu_gnt) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (dma_gnt_w) begin
         mem_we    = dma_we;
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
      end
   end

   always_comb begin
      state_d = ST_IDLE;
      if (cpu_gnt) begin
         state_d = ST_CPU;
      end else if (dma_gnt_w) begin
         state_d = ST_DMA;
      end
   end

   // Read data is captured in the grant cycle; it is only reported when last owner was DMA.
   assign rd_pend_d   = dma_gnt_w && !dma_we;
   assign dma_rdata_d = rd_pend_d ? mem_rdata : dma_rdata_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         rd_pend_q   <= 1'b0;
         dma_rdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         rd_pend_q   <= rd_pend_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

   assign dma_rvalid = (state_q == ST_DMA) && rd_pend_q;
   assign dma_rdata  = dma_rdata_q;

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001: Parameter STARVE_MAX, default 4, is the number of consecutive CPU grants with dma_req pending before the DMA port is forced a grant (legal range 1..15).
REQ-002: clk  input  1  single clock; all state changes on its rising edge.
REQ-003: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004: cpu_req  input  1  CPU memory-stage access request.
REQ-005: cpu_we  input  1  CPU write enable (MemWriteM).
REQ-006: cpu_addr  input  32  CPU byte address (ALUOutM).
REQ-007: cpu_wdata  input  32  CPU write data (WriteDataM).
REQ-008: cpu_rdata  output  32  CPU read data, combinational.
REQ-009: cpu_stall  output  1  CPU must hold its request, combinational.
REQ-010: dma_req  input  1  DMA/debug request, held until granted.
REQ-011: dma_we, dma_addr[31:0], dma_wdata[31:0]  input  DMA write enable, byte address and write data.
REQ-012: dma_gnt  output  1  one-cycle pulse; the DMA access is performed in this cycle.
REQ-013: dma_rdata  output  32  registered DMA read data.
REQ-014: dma_rvalid  output  1  dma_rdata valid, one-cycle pulse.
REQ-015: mem_we  output  1, mem_addr  output  32, mem_wdata  output  32, mem_rdata  input  32: single-port data-memory interface (synchronous write, combinational read).

Function
REQ-016: Exactly one requester owns mem per cycle; owner is decided combinationally from cpu_req, dma_req and the registered state.
REQ-017: FSM state (last cycle's owner): IDLE, CPU, DMA; next state = CPU if CPU granted, DMA if DMA granted, else IDLE.
REQ-018: Base policy: CPU has priority; DMA is granted when dma_req=1 and cpu_req=0.
REQ-019: cpu_stall = cpu_req AND NOT CPU-granted; when cpu_req=0, cpu_stall=0.
REQ-020: When CPU is granted: mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata, cpu_rdata=mem_rdata in the same cycle.
REQ-021: When DMA is granted: mem_we=dma_we, mem_addr=dma_addr, mem_wdata=dma_wdata, dma_gnt=1.
REQ-022: When nobody is granted: mem_we=0, mem_addr=0, mem_wdata=0; cpu_rdata=0 whenever CPU is not granted.
REQ-023: A DMA read (dma_we=0) granted in cycle N produces dma_rvalid=1 and dma_rdata=mem_rdata(N) in cycle N+1; DMA writes produce no dma_rvalid.
REQ-024: dma_rdata holds its last value when dma_rvalid=0.
REQ-025: Back-to-back DMA grants are allowed; dma_gnt may be high in consecutive cycles and dma_rvalid then tracks each read with 1-cycle latency.
REQ-026: A DMA write and a CPU read to the same address never coincide (single owner); a CPU read after a DMA write in the previous cycle returns the new data.

Reset
REQ-027: While reset=0: state=IDLE, starvation counter=0, dma_rvalid=0, dma_rdata=0; combinational outputs then follow REQ-018..022 from the reset state.
REQ-028: Reset asserted during a DMA read cycle discards the pending dma_rvalid; the DMA port must re-request.
REQ-029: Reset deassertion is taken synchronously to clk; first arbitration occurs on the first rising edge after release.

Configuration
REQ-030: Macro DMEM_ARB_STARVE_EN compiles in the fairness counter (4 bits).
REQ-031: With DMEM_ARB_STARVE_EN: counter increments on each cycle CPU is granted while dma_req=1, clears on any DMA grant or when dma_req=0; when counter = STARVE_MAX, DMA is granted next cycle regardless of cpu_req (CPU stalls) and counter clears.
REQ-032: Without DMEM_ARB_STARVE_EN: strict CPU priority, no counter; DMA may starve indefinitely.

Verification
REQ-033: Reset release, cpu_req=1, cpu_we=1, addr=0x10, wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x10, cpu_stall=0 same cycle.
REQ-034: cpu_req=0, dma_req=1, dma_we=0, addr=0x20, mem holds 0x12345678 -> dma_gnt=1 cycle N; dma_rvalid=1, dma_rdata=0x12345678 cycle N+1.
REQ-035: cpu_req and dma_req both held high, STARVE_EN on, STARVE_MAX=4 -> CPU granted 4 cycles, DMA granted cycle 5 with cpu_stall=1, CPU granted again cycle 6.
REQ-036: Same stimulus as REQ-035 without DMEM_ARB_STARVE_EN -> dma_gnt stays 0 for 100 cycles, cpu_stall stays 0.
REQ-037: DMA read granted cycle N, reset asserted asynchronously before edge N+1 -> dma_rvalid=0, dma_rdata=0, state IDLE.
REQ-038: DMA write 0xCAFEF00D to 0x08 cycle N, CPU read 0x08 cycle N+1 -> cpu_rdata=0xCAFEF00D, cpu_stall=0.
